store_write_buffer: RTL and testbench

//  FIFO write buffer between the MR stage and the data memory write port.
//  The MR stage pushes each store in one cycle. The buffer drains entries to memory

---
 rtl/store_write_buffer_if.sv | 35 +++
 rtl/store_write_buffer.sv | 90 +++++++++
 tb/tb_store_write_buffer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/store_write_buffer_if.sv
// Bundle of store, load-forwarding and memory-drain signals for the store write buffer.
// The buffer takes the slave view; the pipeline/memory side takes the master view.
interface store_write_buffer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          st_valid;
    logic [AW-1:0] st_addr;
    logic [DW-1:0] st_data;
    logic          st_ready;
    logic          stall;
    logic          ld_valid;
    logic [AW-1:0] ld_addr;
    logic          ld_hit;
    logic [DW-1:0] ld_data;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_ack;
    logic          empty;
    logic [CW-1:0] count;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        input  st_ready, stall, ld_hit, ld_data, mem_req, mem_addr, mem_data, empty, count
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_ack,
        output st_ready, stall, ld_hit, ld_data, mem_req, mem_addr, mem_data, empty, count
    );
endinterface

// File: rtl/store_write_buffer.sv
// FIFO store buffer between the MR stage and the data memory write port, draining under
// a req/ack handshake and forwarding the youngest matching pending store to loads.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    store_write_buffer_if.slave  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] r_valid;
    logic [AW-1:0]    r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_mem_req;
    logic          w_ld_hit;
    logic [DW-1:0] w_ld_data;
    logic [PW-1:0] w_idx;

    // Readiness comes from state alone so it never depends on mem_ack in the same cycle.
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_push    = bus.st_valid && !w_full;
    assign w_mem_req = r_valid[r_rd_ptr];
    assign w_pop     = w_mem_req && bus.mem_ack;

    assign bus.st_ready = !w_full;
    assign bus.stall    = bus.st_valid && w_full;
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_addr = w_mem_req ? r_addr[r_rd_ptr] : '0;
    assign bus.mem_data = w_mem_req ? r_data[r_rd_ptr] : '0;
    assign bus.empty    = (r_count == '0);
    assign bus.count    = r_count;
    assign bus.ld_hit   = w_ld_hit;
    assign bus.ld_data  = w_ld_data;

    // Scan oldest to youngest starting at wr_ptr so the last match is the youngest, across wrap.
    always_comb begin
        w_ld_hit  = 1'b0;
        w_ld_data = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_wr_ptr + PW'(k);
            if (bus.ld_valid && r_valid[w_idx] && (r_addr[w_idx] == bus.ld_addr)) begin
                w_ld_hit  = 1'b1;
                w_ld_data = r_data[w_idx];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_valid[r_wr_ptr] <= 1'b1;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset; it is only observed through a set valid bit.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= bus.st_addr;
            r_data[r_wr_ptr] <= bus.st_data;
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Directed self-checking bench for store_write_buffer; memory writes are logged at the
// negative edge into queues so drain order can be checked against hand-computed values.
module tb_store_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 16;
    localparam int DW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   testsRun    = 0;
    int   testsFailed = 0;
    logic [AW-1:0] wrAddrQ[$];
    logic [DW-1:0] wrDataQ[$];

    store_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus();

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // A write commits at the next rising edge when req and ack are both high mid-cycle.
    always @(negedge clk) begin
        if (!rst && bus.mem_req && bus.mem_ack) begin
            wrAddrQ.push_back(bus.mem_addr);
            wrDataQ.push_back(bus.mem_data);
        end
    end

    always @(posedge clk) begin
        if (!rst) assert (!(bus.st_valid && bus.ld_valid)) else $error("[TB] store and load presented together");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll();
        bus.mem_ack = 1'b1;
        for (int n = 0; n < 20 && bus.empty !== 1'b1; n++) tick();
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0;
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.mem_ack = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        testsRun++; if (bus.st_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_st_ready: got %b expected 1", bus.st_ready); end
        testsRun++; if (bus.stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall); end
        testsRun++; if (bus.mem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_mem_req: got %b expected 0", bus.mem_req); end
        testsRun++; if (bus.mem_addr !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
        testsRun++; if (bus.mem_data !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_mem_data: got %h expected 0000", bus.mem_data); end
        testsRun++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 16'h0) begin testsFailed++; $display("[TB] FAIL reset_ld: got hit=%b data=%h expected 0/0000", bus.ld_hit, bus.ld_data); end
        testsRun++; if (bus.empty !== 1'b1 || bus.count !== 3'd0) begin testsFailed++; $display("[TB] FAIL reset_empty_count: got empty=%b count=%0d expected 1/0", bus.empty, bus.count); end
    endtask

    task automatic test_push_reset();
        bus.st_valid = 1'b1; bus.st_addr = 16'h0010; bus.st_data = 16'hAAAA;
        tick();
        bus.st_valid = 1'b0;
        testsRun++; if (bus.mem_req !== 1'b1) begin testsFailed++; $display("[TB] FAIL push_mem_req: got %b expected 1", bus.mem_req); end
        testsRun++; if (bus.mem_addr !== 16'h0010 || bus.mem_data !== 16'hAAAA) begin testsFailed++; $display("[TB] FAIL push_head: got %h/%h expected 0010/aaaa", bus.mem_addr, bus.mem_data); end
        testsRun++; if (bus.count !== 3'd1) begin testsFailed++; $display("[TB] FAIL push_count: got %0d expected 1", bus.count); end
        rst = 1'b1;
        tick();
        testsRun++; if (bus.mem_req !== 1'b0 || bus.count !== 3'd0 || bus.empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_discard: got req=%b count=%0d empty=%b expected 0/0/1", bus.mem_req, bus.count, bus.empty); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_stall();
        wrAddrQ.delete(); wrDataQ.delete();
        for (int i = 0; i < 4; i++) begin
            bus.st_valid = 1'b1; bus.st_addr = 16'h0100 + 16'(i); bus.st_data = 16'h5000 + 16'(i);
            tick();
        end
        bus.st_addr = 16'h0104; bus.st_data = 16'h5004;
        #1;
        testsRun++; if (bus.count !== 3'd4 || bus.st_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_state: got count=%0d ready=%b expected 4/0", bus.count, bus.st_ready); end
        testsRun++; if (bus.stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_stall: got %b expected 1", bus.stall); end
        tick();
        testsRun++; if (bus.count !== 3'd4 || bus.mem_addr !== 16'h0100) begin testsFailed++; $display("[TB] FAIL full_no_write: got count=%0d head=%h expected 4/0100", bus.count, bus.mem_addr); end
        bus.mem_ack = 1'b1;
        #1;
        testsRun++; if (bus.stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL stall_during_ack: got %b expected 1", bus.stall); end
        tick();
        bus.mem_ack = 1'b0;
        #1;
        testsRun++; if (bus.count !== 3'd3 || bus.stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL after_ack: got count=%0d stall=%b expected 3/0", bus.count, bus.stall); end
        tick();
        bus.st_valid = 1'b0;
        testsRun++; if (bus.count !== 3'd4) begin testsFailed++; $display("[TB] FAIL held_store_accepted: got count=%0d expected 4", bus.count); end
        drainAll();
        testsRun++; if (bus.empty !== 1'b1 || wrAddrQ.size() != 5) begin testsFailed++; $display("[TB] FAIL full_drain: got empty=%b writes=%0d expected 1/5", bus.empty, wrAddrQ.size()); end
        for (int i = 0; i < 5 && i < wrAddrQ.size(); i++) begin
            testsRun++;
            if (wrAddrQ[i] !== 16'h0100 + 16'(i) || wrDataQ[i] !== 16'h5000 + 16'(i)) begin
                testsFailed++; $display("[TB] FAIL full_order[%0d]: got %h/%h expected %h/%h", i, wrAddrQ[i], wrDataQ[i], 16'h0100 + 16'(i), 16'h5000 + 16'(i));
            end
        end
    endtask

    task automatic test_forward();
        wrAddrQ.delete(); wrDataQ.delete();
        bus.st_valid = 1'b1; bus.st_addr = 16'h0020; bus.st_data = 16'h1111;
        tick();
        bus.st_data = 16'h2222;
        tick();
        bus.st_valid = 1'b0;
        testsRun++; if (bus.count !== 3'd2) begin testsFailed++; $display("[TB] FAIL no_coalesce: got count=%0d expected 2", bus.count); end
        bus.ld_valid = 1'b1; bus.ld_addr = 16'h0020;
        #1;
        testsRun++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 16'h2222) begin testsFailed++; $display("[TB] FAIL fwd_youngest: got hit=%b data=%h expected 1/2222", bus.ld_hit, bus.ld_data); end
        bus.ld_addr = 16'h0021;
        #1;
        testsRun++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 16'h0) begin testsFailed++; $display("[TB] FAIL fwd_miss: got hit=%b data=%h expected 0/0000", bus.ld_hit, bus.ld_data); end
        bus.ld_valid = 1'b0;
        drainAll();
        testsRun++; if (wrDataQ.size() != 2 || wrDataQ[0] !== 16'h1111 || wrDataQ[1] !== 16'h2222) begin testsFailed++; $display("[TB] FAIL fwd_drain: got %0d writes first=%h expected 2 writes 1111,2222", wrDataQ.size(), (wrDataQ.size() > 0) ? wrDataQ[0] : 16'h0); end
    endtask

    task automatic test_back_to_back();
        wrAddrQ.delete(); wrDataQ.delete();
        bus.mem_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.st_valid = 1'b1; bus.st_addr = 16'h0040 + 16'(i); bus.st_data = 16'h7000 + 16'(i);
            #1;
            testsRun++; if (bus.count > 3'd1 || bus.stall !== 1'b0) begin testsFailed++; $display("[TB] FAIL b2b_count[%0d]: got count=%0d stall=%b expected <=1/0", i, bus.count, bus.stall); end
            tick();
        end
        bus.st_valid = 1'b0;
        drainAll();
        testsRun++; if (bus.empty !== 1'b1 || wrAddrQ.size() != 10) begin testsFailed++; $display("[TB] FAIL b2b_total: got empty=%b writes=%0d expected 1/10", bus.empty, wrAddrQ.size()); end
        for (int i = 0; i < 10 && i < wrAddrQ.size(); i++) begin
            testsRun++;
            if (wrAddrQ[i] !== 16'h0040 + 16'(i) || wrDataQ[i] !== 16'h7000 + 16'(i)) begin
                testsFailed++; $display("[TB] FAIL b2b_order[%0d]: got %h/%h expected %h/%h", i, wrAddrQ[i], wrDataQ[i], 16'h0040 + 16'(i), 16'h7000 + 16'(i));
            end
        end
    endtask

    task automatic test_full_push_ack();
        wrAddrQ.delete(); wrDataQ.delete();
        for (int i = 0; i < 4; i++) begin
            bus.st_valid = 1'b1; bus.st_addr = 16'h0050 + 16'(i); bus.st_data = 16'h6000 + 16'(i);
            tick();
        end
        bus.st_addr = 16'h0054; bus.st_data = 16'h6004; bus.mem_ack = 1'b1;
        #1;
        testsRun++; if (bus.st_ready !== 1'b0 || bus.stall !== 1'b1) begin testsFailed++; $display("[TB] FAIL pushack_stall: got ready=%b stall=%b expected 0/1", bus.st_ready, bus.stall); end
        tick();
        bus.mem_ack = 1'b0;
        testsRun++; if (bus.count !== 3'd3) begin testsFailed++; $display("[TB] FAIL pushack_pop_only: got count=%0d expected 3", bus.count); end
        tick();
        bus.st_valid = 1'b0;
        testsRun++; if (bus.count !== 3'd4) begin testsFailed++; $display("[TB] FAIL pushack_refill: got count=%0d expected 4", bus.count); end
        drainAll();
        testsRun++; if (wrAddrQ.size() != 5 || wrAddrQ[4] !== 16'h0054 || wrDataQ[4] !== 16'h6004) begin testsFailed++; $display("[TB] FAIL pushack_drain: got %0d writes expected 5 ending 0054/6004", wrAddrQ.size()); end
    endtask

    task automatic test_ack_forward();
        wrAddrQ.delete(); wrDataQ.delete();
        bus.st_valid = 1'b1; bus.st_addr = 16'h0030; bus.st_data = 16'hBEEF;
        tick();
        bus.st_valid = 1'b0;
        testsRun++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 16'h0030) begin testsFailed++; $display("[TB] FAIL ackfwd_head: got req=%b addr=%h expected 1/0030", bus.mem_req, bus.mem_addr); end
        bus.mem_ack = 1'b1; bus.ld_valid = 1'b1; bus.ld_addr = 16'h0030;
        #1;
        testsRun++; if (bus.ld_hit !== 1'b1 || bus.ld_data !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL ackfwd_hit: got hit=%b data=%h expected 1/beef", bus.ld_hit, bus.ld_data); end
        tick();
        bus.mem_ack = 1'b0;
        #1;
        testsRun++; if (bus.ld_hit !== 1'b0 || bus.ld_data !== 16'h0 || bus.empty !== 1'b1) begin testsFailed++; $display("[TB] FAIL ackfwd_after: got hit=%b data=%h empty=%b expected 0/0000/1", bus.ld_hit, bus.ld_data, bus.empty); end
        testsRun++; if (wrAddrQ.size() != 1 || wrAddrQ[0] !== 16'h0030 || wrDataQ[0] !== 16'hBEEF) begin testsFailed++; $display("[TB] FAIL ackfwd_mem: got %0d writes expected 1 write 0030/beef", wrAddrQ.size()); end
        bus.ld_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_push_reset();
        test_full_stall();
        test_forward();
        test_back_to_back();
        test_full_push_ack();
        test_ack_forward();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
